// File: rtl/game_engine_pkg.sv
// Shared constants and types for the game_engine AXI4-Lite master.
package game_engine_pkg;

    // AXI4-Lite response codes
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    // Default response-wait limit in cycles
    localparam int DEFAULT_TIMEOUT = 1024;

    // Byte offsets of the game_engine slave registers 0-3
    localparam logic [31:0] REG0_OFFSET = 32'h0000_0000;
    localparam logic [31:0] REG1_OFFSET = 32'h0000_0004;
    localparam logic [31:0] REG2_OFFSET = 32'h0000_0008;
    localparam logic [31:0] REG3_OFFSET = 32'h0000_000C;

    // Master transaction states
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ADDR_WR = 3'd1,
        WAIT_B  = 3'd2,
        ADDR_RD = 3'd3,
        WAIT_R  = 3'd4,
        RSP     = 3'd5
    } state_t;

endpackage

// File: rtl/game_engine_resp_wdt.sv
// Response watchdog: counts cycles spent waiting for BVALID/RVALID and
// flags expiry once the count reaches C_TIMEOUT-1.
module game_engine_resp_wdt
    import game_engine_pkg::*;
#(
    parameter int C_TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam int CW = $clog2(C_TIMEOUT);
    localparam logic [CW-1:0] LAST = CW'(C_TIMEOUT - 1);

    logic [CW-1:0] cnt;

    // Count while enabled; held at zero whenever not waiting for a response
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + CW'(1);
        end
    end

    assign expire = (cnt == LAST);

endmodule

// File: rtl/game_engine_axil_master.sv
// Single-outstanding AXI4-Lite master driven by a valid/ready command port.
// Handshake rule on every channel: a transfer happens on a rising edge where
// VALID and READY are both high; VALID is never withdrawn before READY.
module game_engine_axil_master
    import game_engine_pkg::*;
#(
    parameter int                            C_M_AXI_ADDR_WIDTH = 32,
    parameter int                            C_M_AXI_DATA_WIDTH = 32,
    parameter logic [C_M_AXI_ADDR_WIDTH-1:0] C_BASE_ADDR        = '0,
    parameter int                            C_TIMEOUT          = DEFAULT_TIMEOUT
) (
    input  logic                              ACLK,
    input  logic                              ARESET,

    input  logic                              cmd_valid,
    output logic                              cmd_ready,
    input  logic                              cmd_write,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0]     cmd_addr,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]     cmd_wdata,
    input  logic [C_M_AXI_DATA_WIDTH/8-1:0]   cmd_wstrb,

    output logic                              rsp_valid,
    input  logic                              rsp_ready,
    output logic [C_M_AXI_DATA_WIDTH-1:0]     rsp_rdata,
    output logic [1:0]                        rsp_resp,
    output logic                              rsp_timeout,

    output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_AWADDR,
    output logic [2:0]                        M_AXI_AWPROT,
    output logic                              M_AXI_AWVALID,
    input  logic                              M_AXI_AWREADY,
    output logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_WDATA,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
    output logic                              M_AXI_WVALID,
    input  logic                              M_AXI_WREADY,
    input  logic [1:0]                        M_AXI_BRESP,
    input  logic                              M_AXI_BVALID,
    output logic                              M_AXI_BREADY,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_ARADDR,
    output logic [2:0]                        M_AXI_ARPROT,
    output logic                              M_AXI_ARVALID,
    input  logic                              M_AXI_ARREADY,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_RDATA,
    input  logic [1:0]                        M_AXI_RRESP,
    input  logic                              M_AXI_RVALID,
    output logic                              M_AXI_RREADY
);

    localparam int AW = C_M_AXI_ADDR_WIDTH;
    localparam int DW = C_M_AXI_DATA_WIDTH;
    localparam int SW = C_M_AXI_DATA_WIDTH / 8;
    localparam logic [AW-1:0] WORD_MASK = {{(AW-2){1'b1}}, 2'b00};

    state_t state, state_next;

    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic [SW-1:0] wstrb_q;
    logic [DW-1:0] rdata_q;
    logic [1:0]    resp_q;
    logic          timeout_q;
    logic          aw_done;
    logic          w_done;

    logic [AW-1:0] addr_sum;
    logic          cmd_accept;
    logic          aw_fin;
    logic          w_fin;
    logic          wdt_clr;
    logic          wdt_en;
    logic          wdt_expire;

    // Base-relative address wraps modulo 2^AW and is forced word-aligned
    assign addr_sum   = C_BASE_ADDR + cmd_addr;
    assign cmd_accept = cmd_valid && cmd_ready;
    assign aw_fin     = aw_done || (M_AXI_AWVALID && M_AXI_AWREADY);
    assign w_fin      = w_done  || (M_AXI_WVALID  && M_AXI_WREADY);

    // Watchdog only runs in the response-wait states
    assign wdt_clr = !((state == WAIT_B) || (state == WAIT_R));
    assign wdt_en  = ((state == WAIT_B) && !M_AXI_BVALID) ||
                     ((state == WAIT_R) && !M_AXI_RVALID);

    game_engine_resp_wdt #(
        .C_TIMEOUT (C_TIMEOUT)
    ) u_wdt (
        .clk    (ACLK),
        .rst    (ARESET),
        .clr    (wdt_clr),
        .en     (wdt_en),
        .expire (wdt_expire)
    );

    // State register
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; a response arriving on the expiry cycle takes priority
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (cmd_valid)                    state_next = cmd_write ? ADDR_WR : ADDR_RD;
            ADDR_WR: if (aw_fin && w_fin)              state_next = WAIT_B;
            WAIT_B:  if (M_AXI_BVALID || wdt_expire)   state_next = RSP;
            ADDR_RD: if (M_AXI_ARREADY)                state_next = WAIT_R;
            WAIT_R:  if (M_AXI_RVALID || wdt_expire)   state_next = RSP;
            RSP:     if (rsp_ready)                    state_next = IDLE;
            default:                                   state_next = IDLE;
        endcase
    end

    // Output decode; cmd_ready is held low while reset is asserted
    always_comb begin
        cmd_ready     = (state == IDLE) && !ARESET;
        M_AXI_AWVALID = (state == ADDR_WR) && !aw_done;
        M_AXI_WVALID  = (state == ADDR_WR) && !w_done;
        M_AXI_BREADY  = (state == WAIT_B);
        M_AXI_ARVALID = (state == ADDR_RD);
        M_AXI_RREADY  = (state == WAIT_R);
        rsp_valid     = (state == RSP);
        M_AXI_AWADDR  = addr_q;
        M_AXI_ARADDR  = addr_q;
        M_AXI_WDATA   = wdata_q;
        M_AXI_WSTRB   = wstrb_q;
        M_AXI_AWPROT  = 3'b000;
        M_AXI_ARPROT  = 3'b000;
        rsp_rdata     = rdata_q;
        rsp_resp      = resp_q;
        rsp_timeout   = timeout_q;
    end

    // Command latch, per-channel handshake tracking and response capture
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            rdata_q   <= '0;
            resp_q    <= RESP_OKAY;
            timeout_q <= 1'b0;
            aw_done   <= 1'b0;
            w_done    <= 1'b0;
        end else begin
            if (cmd_accept) begin
                addr_q  <= addr_sum & WORD_MASK;
                wdata_q <= cmd_wdata;
                wstrb_q <= cmd_wstrb;
                aw_done <= 1'b0;
                w_done  <= 1'b0;
            end
            if (state == ADDR_WR) begin
                if (M_AXI_AWVALID && M_AXI_AWREADY) aw_done <= 1'b1;
                if (M_AXI_WVALID && M_AXI_WREADY)   w_done  <= 1'b1;
            end
            if (state == WAIT_B) begin
                if (M_AXI_BVALID) begin
                    resp_q    <= M_AXI_BRESP;
                    rdata_q   <= '0;
                    timeout_q <= 1'b0;
                end else if (wdt_expire) begin
                    resp_q    <= RESP_SLVERR;
                    rdata_q   <= '0;
                    timeout_q <= 1'b1;
                end
            end
            if (state == WAIT_R) begin
                if (M_AXI_RVALID) begin
                    resp_q    <= M_AXI_RRESP;
                    rdata_q   <= M_AXI_RDATA;
                    timeout_q <= 1'b0;
                end else if (wdt_expire) begin
                    resp_q    <= RESP_SLVERR;
                    rdata_q   <= '0;
                    timeout_q <= 1'b1;
                end
            end
        end
    end

endmodule

// File: doc/game_engine_axil_master.md
Name: game_engine_axil_master

Overview:
- Hardware AXI4-Lite master that sits directly upstream of the game_engine AXI4-Lite slave (S00_AXI).
- Replaces the simulation BFM in the integrated design: game logic issues single register commands over a valid/ready command port; the block executes one AXI4-Lite write or read and returns the response.
- One outstanding transaction at a time.
- Write and read phase ordering matches the slave's validated usage: concurrent AW/W, then B; AR, then R.

Parameters:
- C_M_AXI_ADDR_WIDTH, 32, AXI address width.
- C_M_AXI_DATA_WIDTH, 32, AXI data width; only 32 is supported.
- C_BASE_ADDR, 32'h0000_0000, added to cmd_addr to form the AXI address.
- C_TIMEOUT, 1024, maximum cycles to wait for BVALID/RVALID; must be at least 2.

Ports:
- ACLK  in  1  clock; all logic on rising edge.
- ARESET  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_W  byte offset from C_BASE_ADDR.
- cmd_wdata  in  32  write data.
- cmd_wstrb  in  4  write byte strobes.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  response consumed.
- rsp_rdata  out  32  read data; 0 for writes.
- rsp_resp  out  2  BRESP/RRESP, or SLVERR on timeout.
- rsp_timeout  out  1  transaction timed out.
- M_AXI_AWADDR out ADDR_W; M_AXI_AWPROT out 3; M_AXI_AWVALID out 1; M_AXI_AWREADY in 1.
- M_AXI_WDATA out 32; M_AXI_WSTRB out 4; M_AXI_WVALID out 1; M_AXI_WREADY in 1.
- M_AXI_BRESP in 2; M_AXI_BVALID in 1; M_AXI_BREADY out 1.
- M_AXI_ARADDR out ADDR_W; M_AXI_ARPROT out 3; M_AXI_ARVALID out 1; M_AXI_ARREADY in 1.
- M_AXI_RDATA in 32; M_AXI_RRESP in 2; M_AXI_RVALID in 1; M_AXI_RREADY out 1.

Behaviour:
- Clock and reset: one clock, ACLK; ARESET is synchronous and active-high.
- Reset state:
  - All outputs 0, including cmd_ready; state IDLE.
  - Reset asserted mid-transaction abandons it; on the next edge all VALID/READY outputs are 0 and rsp_valid is 0.
- States: IDLE, ADDR_WR, WAIT_B, ADDR_RD, WAIT_R, RSP.
- IDLE:
  - cmd_ready = 1.
  - On accept, latch AXI address = (C_BASE_ADDR + cmd_addr) mod 2^ADDR_W with bits [1:0] forced to 0; also latch wdata and wstrb.
  - Go to ADDR_WR if cmd_write, else ADDR_RD. AWVALID+WVALID (or ARVALID) are high the cycle after accept.
- cmd_ready = 0 in every state except IDLE.
- ADDR_WR:
  - AWVALID and WVALID are asserted together and cleared independently; each drops the cycle after its READY is sampled high.
  - The AW and W handshakes may complete in either order or in the same cycle.
  - VALID is never withdrawn before READY.
  - When both handshakes are done, go to WAIT_B with BREADY = 1.
- WAIT_B: on BVALID, capture BRESP, set rsp_rdata = 0, drop BREADY, go to RSP.
- ADDR_RD: ARVALID held until ARREADY; then go to WAIT_R with RREADY = 1.
- WAIT_R: on RVALID, capture RDATA/RRESP, drop RREADY, go to RSP.
- Timeout:
  - Counter clears on entry to WAIT_B/WAIT_R and increments each cycle without the response.
  - When the count reaches C_TIMEOUT-1: drop BREADY/RREADY, set rsp_resp = 2'b10, rsp_timeout = 1, rsp_rdata = 0, go to RSP.
  - A response arriving in the same cycle as the timeout wins; rsp_timeout = 0.
  - Address phases have no timeout (AXI forbids dropping VALID).
- RSP:
  - rsp_valid = 1 with stable data until rsp_ready; then IDLE.
  - rsp_ready already high gives a single-cycle RSP.
  - A new command cannot be accepted in the same cycle RSP completes.
- Constants: AWPROT = ARPROT = 3'b000.
- Minimum write latency, with all slave READYs high: accept N, AW/W N+1, B at N+2, rsp_valid N+3.

Decomposition:
- game_engine_pkg holds:
  - RESP_OKAY/EXOKAY/SLVERR/DECERR constants;
  - state enum;
  - default C_TIMEOUT;
  - register offsets 0x0/0x4/0x8/0xC for slave regs 0-3.
- One sub-module is natural: game_engine_resp_wdt (timeout counter with clear/enable/expire).

Test Plan:
- Write then read back offsets 0x0/0x4/0x8/0xC with 0x0101FFFF, 0xabcd0001, 0xdead0011, 0xbeef0011 against game_engine -> every rsp_resp = 00 and every read rsp_rdata matches the written value.
- Slave holds AWREADY low 5 cycles while WREADY is immediate -> WVALID drops after 1 cycle, AWVALID held 6 cycles, BREADY asserts only after both handshakes.
- Read with a slave that never asserts RVALID, C_TIMEOUT = 16 -> rsp_valid with rsp_resp = 10 and rsp_timeout = 1 exactly 16 cycles after RREADY rose; RREADY = 0.
- RVALID arrives on the expiry cycle -> normal response, rsp_timeout = 0.
- rsp_ready held low 10 cycles with cmd_valid high -> rsp fields stable, cmd_ready stays 0, no new AXI activity.
- ARESET pulsed while WAIT_B -> next cycle all AXI VALID/READY = 0, rsp_valid = 0, cmd_ready = 1 after reset deasserts.
